bitty_control_unit_gen2: RTL and testbench
==========================================

# bitty_control_unit_gen2

Parametrised second-generation control unit for the bitty datapath. It decodes the fixed 16-bit instruction word and sequences source select, ALU execute, load/store wait and register write-back. It drives the shared datapath mux, ALU, register-file enables and the load/store unit. Compared with the first generation it adds a data-width parameter, one-hot register enables, conditional branches with compare flags, and a bounded load/store wait with an error report.

## Interface
Parameters:
- DATA_W, 16, width of the `imm` output; must be ≥ 12.
- LS_TIMEOUT, 64, maximum number of LSWAIT cycles; must be ≥ 1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock; all state changes on the rising edge.
  - reset  in  1  asynchronous active-low reset.
- Inputs:
  - run  in  1  start execution of the current `instruction`.
  - instruction  in  16  field layout:
    - rx = [15:13], ry = [12:10]
    - imm8 = [12:5], alu_op = [4:2], fmt = [1:0]
    - For fmt 10: target = [15:4], cond = [3:2].
  - ls_done  in  1  load/store unit completion.
  - cmp_eq, cmp_gt, cmp_lt  in  1 each  compare flags from the ALU status register.
- Outputs:
  - alu_sel  out  3  ALU operation.
  - mux_sel  out  4  datapath source select:
    - 0–7 select a register.
    - 8 selects `imm`.
    - 9 selects idle.
  - imm  out  DATA_W  zero-extended immediate:
    - fmt 10: instr[15:4].
    - Otherwise: instr[12:5].
  - en_ls  out  2  load/store request: 01 = load, 10 = store.
  - sel_to_reg_c  out  1  C register takes load/store data.
  - en_s, en_c  out  1 each  source and result register enables.
  - en_reg  out  8  one-hot register-file write enable.
  - en_i  out  1  instruction register enable.
  - done  out  1  one-cycle end-of-instruction pulse.
  - branch_taken  out  1  PC load strobe; the target is on `imm`.
  - ls_err  out  1  the load/store that just finished timed out.

## Operation
- States: SRC, EXEC, LSWAIT, WB. Outputs are combinational from the state and `instruction`; any output not listed below is 0.
- SRC:
  - Outputs: en_i=1.
    - fmt≠10: mux_sel={0,rx} and en_s=1.
    - fmt=10: mux_sel=9.
  - Transitions:
    - run=0: stay in SRC.
    - run=1 and fmt=10: go to WB.
    - run=1 otherwise: go to EXEC.
- EXEC:
  - Outputs:
    - Always: en_c=1, en_i=0, alu_sel=instr[4:2].
    - fmt 00: mux_sel={0,ry}.
    - fmt 01: mux_sel=8.
    - fmt 11: mux_sel={0,ry}, en_ls=(instr[2] ? 10 : 01), sel_to_reg_c=1.
  - Transitions:
    - fmt 11: go to LSWAIT.
    - Otherwise: go to WB.
  - ls_done is ignored in EXEC.
- LSWAIT:
  - Outputs are the same as fmt-11 EXEC, including en_c=1.
  - A timeout counter is cleared on entry and increments on each cycle with ls_done=0.
  - ls_done=1: go to WB.
  - Counter = LS_TIMEOUT−1 and ls_done=0: go to WB and set the internal err flag.
- WB:
  - Outputs: done=1, en_i=1; sel_to_reg_c=1 when fmt 11.
  - en_reg[rx]=1 except in these cases:
    - fmt 10.
    - Store (fmt 11 with instr[2]=1).
    - err flag set.
  - fmt 10: branch_taken = the condition, selected by cond:
    - 00: cmp_eq.
    - 01: cmp_gt.
    - 10: cmp_lt.
    - 11: 1.
  - ls_err is the err flag. The flag clears on leaving WB.
  - Transition: always go to SRC.

## Timing
- Reset, asynchronous: state=SRC, counter=0, err flag=0.
  - While in reset: done=0, en_c=0, en_reg=0, en_ls=00, branch_taken=0, ls_err=0, en_i=1.
  - mux_sel and en_s follow the SRC decode of `instruction`.
- Latency from the run edge to done:
  - ALU or immediate instruction: 2 cycles (SRC→EXEC→WB).
  - Branch: 1 cycle.
  - Load/store: 2 + n cycles, where n = number of LSWAIT cycles, 1 ≤ n ≤ LS_TIMEOUT.
- ls_done on the final permitted LSWAIT cycle counts as success: no error.
- run asserted during WB is ignored. A new instruction is accepted in SRC only.
- Reset asserted in any state aborts the instruction. No en_reg pulse is emitted after reset assertion.

## Configuration
- CU_LS_TIMEOUT_EN:
  - Defined: the timeout counter and err flag are built.
  - Undefined: LSWAIT waits indefinitely for ls_done, ls_err is tied to 0, and LS_TIMEOUT is unused.

## Test plan
- ALU instruction: instruction=0x5400 (rx=2, ry=5, fmt 00), run=1 in SRC.
  - Cycle 0: mux_sel=2, en_s=1.
  - Cycle 1: mux_sel=5, en_c=1.
  - Cycle 2: en_reg=0x04, done=1.
- Immediate instruction: instruction=0x2541.
  - EXEC: mux_sel=8, imm=0x002A.
  - WB: en_reg=0x02.
- Load: instruction=0x7003, ls_done asserted on the 3rd LSWAIT cycle.
  - en_ls=01 through EXEC and LSWAIT.
  - WB: sel_to_reg_c=1, en_reg=0x08, ls_err=0.
- Store: instruction=0x7007.
  - en_ls=10 and no en_reg pulse.
- Timeout, with CU_LS_TIMEOUT_EN defined and LS_TIMEOUT=4: instruction=0x7003, ls_done held at 0.
  - WB is reached after exactly 4 LSWAIT cycles with ls_err=1 and en_reg=0.
  - Repeat with ls_done on LSWAIT cycle 4: ls_err=0.
- Branches:
  - instruction=0x123E: branch_taken=1 and imm=0x0123 in WB, one cycle after run.
  - instruction=0x1232 with cmp_eq=0: branch_taken=0.
  - Assert reset mid-LSWAIT: state returns to SRC at once and no done pulse is emitted.

Source files
------------

// File: rtl/bitty_control_unit_gen2.sv
// bitty_control_unit_gen2: instruction sequencer for the bitty datapath.
// Decodes the 16-bit instruction word and steps it through
// source select, ALU execute, load/store wait and register write-back.
//
// Optional feature macro: CU_LS_TIMEOUT_EN
//   defined   -> LSWAIT is bounded to LS_TIMEOUT cycles; a timeout suppresses
//                the write-back and is reported on ls_err.
//   undefined -> LSWAIT waits for ls_done indefinitely and ls_err is 0.
//
// The instruction word is not latched here. It must stay stable from the run
// cycle through WB, because every output is decoded from it directly.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_SRC    | idle / fetch: first operand on the mux, wait for run
// ST_EXEC   | ALU operation; load/store request is issued
// ST_LSWAIT | hold the load/store request until ls_done (or timeout)
// ST_WB     | register write-back, branch strobe, one-cycle done pulse

module bitty_control_unit_gen2 #(
    parameter int DATA_W     = 16,
    parameter int LS_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [15:0]       instruction,
    input  logic              ls_done,
    input  logic              cmp_eq,
    input  logic              cmp_gt,
    input  logic              cmp_lt,
    output logic [2:0]        alu_sel,
    output logic [3:0]        mux_sel,
    output logic [DATA_W-1:0] imm,
    output logic [1:0]        en_ls,
    output logic              sel_to_reg_c,
    output logic              en_s,
    output logic              en_c,
    output logic [7:0]        en_reg,
    output logic              en_i,
    output logic              done,
    output logic              branch_taken,
    output logic              ls_err
);

    typedef enum logic [1:0] {
        ST_SRC    = 2'd0,
        ST_EXEC   = 2'd1,
        ST_LSWAIT = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam logic [1:0] FMT_ALU = 2'b00;
    localparam logic [1:0] FMT_IMM = 2'b01;
    localparam logic [1:0] FMT_BR  = 2'b10;
    localparam logic [1:0] FMT_LS  = 2'b11;

    localparam logic [3:0] MUX_IMM  = 4'd8;
    localparam logic [3:0] MUX_IDLE = 4'd9;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  w_rx;
    logic [2:0]  w_ry;
    logic [1:0]  w_fmt;
    logic [2:0]  w_alu_op;
    logic [1:0]  w_cond;
    logic        w_is_store;
    logic [1:0]  w_ls_req;
    logic        w_cond_true;
    logic [11:0] w_imm12;
    logic        w_timeout;
    logic        w_err;

    assign w_rx       = instruction[15:13];
    assign w_ry       = instruction[12:10];
    assign w_alu_op   = instruction[4:2];
    assign w_fmt      = instruction[1:0];
    assign w_cond     = instruction[3:2];
    assign w_is_store = instruction[2];
    assign w_ls_req   = w_is_store ? 2'b10 : 2'b01;

    // Branch target is the 12-bit field; everything else carries imm8.
    assign w_imm12 = (w_fmt == FMT_BR) ? instruction[15:4] : {4'b0000, instruction[12:5]};
    assign imm     = DATA_W'(w_imm12);

    // Branch condition select from the ALU status flags.
    always_comb begin
        w_cond_true = 1'b0;
        case (w_cond)
            2'b00:   w_cond_true = cmp_eq;
            2'b01:   w_cond_true = cmp_gt;
            2'b10:   w_cond_true = cmp_lt;
            default: w_cond_true = 1'b1;
        endcase
    end

`ifdef CU_LS_TIMEOUT_EN
    // Wide enough to hold LS_TIMEOUT-1; at least one bit for LS_TIMEOUT=1.
    localparam int CNT_W = (LS_TIMEOUT > 1) ? $clog2(LS_TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_timeout = (r_state == ST_LSWAIT) && !ls_done &&
                       (r_cnt == CNT_W'(LS_TIMEOUT - 1));
    assign w_err     = r_err;

    // Wait counter: held at zero outside LSWAIT so every wait starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (r_state != ST_LSWAIT)
            r_cnt <= '0;
        else if (!ls_done)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    // Error flag: set by a timeout, lives through WB only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_err <= 1'b0;
        else if (w_timeout)
            r_err <= 1'b1;
        else if (r_state == ST_WB)
            r_err <= 1'b0;
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_err            = 1'b0;
    assign w_unused_timeout = (LS_TIMEOUT > 0);
`endif

    assign ls_err = (r_state == ST_WB) && w_err;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_SRC;
        else
            r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_SRC: begin
                if (run)
                    w_next = (w_fmt == FMT_BR) ? ST_WB : ST_EXEC;
            end
            ST_EXEC: begin
                w_next = (w_fmt == FMT_LS) ? ST_LSWAIT : ST_WB;
            end
            ST_LSWAIT: begin
                if (ls_done || w_timeout)
                    w_next = ST_WB;
            end
            ST_WB: begin
                w_next = ST_SRC;
            end
            default: w_next = ST_SRC;
        endcase
    end

    // Datapath control outputs, decoded from the state and the instruction.
    always_comb begin
        alu_sel      = 3'd0;
        mux_sel      = 4'd0;
        en_ls        = 2'b00;
        sel_to_reg_c = 1'b0;
        en_s         = 1'b0;
        en_c         = 1'b0;
        en_reg       = 8'h00;
        en_i         = 1'b0;
        done         = 1'b0;
        branch_taken = 1'b0;
        case (r_state)
            ST_SRC: begin
                en_i = 1'b1;
                if (w_fmt == FMT_BR) begin
                    mux_sel = MUX_IDLE;
                end else begin
                    mux_sel = {1'b0, w_rx};
                    en_s    = 1'b1;
                end
            end
            ST_EXEC, ST_LSWAIT: begin
                en_c    = 1'b1;
                alu_sel = w_alu_op;
                case (w_fmt)
                    FMT_IMM: mux_sel = MUX_IMM;
                    FMT_LS: begin
                        mux_sel      = {1'b0, w_ry};
                        en_ls        = w_ls_req;
                        sel_to_reg_c = 1'b1;
                    end
                    default: mux_sel = {1'b0, w_ry};
                endcase
            end
            ST_WB: begin
                done         = 1'b1;
                en_i         = 1'b1;
                sel_to_reg_c = (w_fmt == FMT_LS);
                branch_taken = (w_fmt == FMT_BR) && w_cond_true;
                if ((w_fmt != FMT_BR) && !((w_fmt == FMT_LS) && w_is_store) && !w_err)
                    en_reg = 8'h01 << w_rx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bitty_control_unit_gen2.sv
// Directed bench for bitty_control_unit_gen2: a per-cycle vector table plus
// hand-written load/store wait sequences.
module tb_bitty_control_unit_gen2;

    localparam int DATA_W     = 16;
    localparam int LS_TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              run = 1'b0;
    logic [15:0]       instruction = 16'h0000;
    logic              ls_done = 1'b0;
    logic              cmp_eq = 1'b0;
    logic              cmp_gt = 1'b0;
    logic              cmp_lt = 1'b0;
    logic [2:0]        alu_sel;
    logic [3:0]        mux_sel;
    logic [DATA_W-1:0] imm;
    logic [1:0]        en_ls;
    logic              sel_to_reg_c;
    logic              en_s;
    logic              en_c;
    logic [7:0]        en_reg;
    logic              en_i;
    logic              done;
    logic              branch_taken;
    logic              ls_err;

    bitty_control_unit_gen2 #(.DATA_W(DATA_W), .LS_TIMEOUT(LS_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .instruction(instruction),
        .ls_done(ls_done), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
        .alu_sel(alu_sel), .mux_sel(mux_sel), .imm(imm), .en_ls(en_ls),
        .sel_to_reg_c(sel_to_reg_c), .en_s(en_s), .en_c(en_c), .en_reg(en_reg),
        .en_i(en_i), .done(done), .branch_taken(branch_taken), .ls_err(ls_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  mux;
        logic        ens;
        logic        enc;
        logic        eni;
        logic [2:0]  alu;
        logic [1:0]  enls;
        logic        selc;
        logic [7:0]  enreg;
        logic        dn;
        logic        br;
        logic        err;
        logic [15:0] im;
    } outs_t;

    typedef struct {
        logic        rst_b;
        logic        run;
        logic [15:0] ins;
        logic        lsd;
        logic [2:0]  cmp;   // {eq, gt, lt}
        outs_t       exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic outs_t mk(logic [3:0] mux, logic ens, logic enc, logic eni,
                                 logic [2:0] alu, logic [1:0] enls, logic selc,
                                 logic [7:0] enreg, logic dn, logic br, logic err,
                                 logic [15:0] im);
        outs_t o;
        o.mux = mux; o.ens = ens; o.enc = enc; o.eni = eni; o.alu = alu;
        o.enls = enls; o.selc = selc; o.enreg = enreg; o.dn = dn; o.br = br;
        o.err = err; o.im = im;
        return o;
    endfunction

    task automatic add(input logic rst_b, input logic r, input logic [15:0] ins,
                       input logic lsd, input logic [2:0] cmp, input outs_t e);
        vec_t v;
        v.rst_b = rst_b; v.run = r; v.ins = ins; v.lsd = lsd; v.cmp = cmp; v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic outs_t sample();
        return mk(mux_sel, en_s, en_c, en_i, alu_sel, en_ls, sel_to_reg_c,
                  en_reg, done, branch_taken, ls_err, imm);
    endfunction

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic drive(input logic rst_b, input logic r, input logic [15:0] ins,
                         input logic lsd, input logic [2:0] cmp);
        @(negedge clk);
        reset = rst_b; run = r; instruction = ins; ls_done = lsd;
        {cmp_eq, cmp_gt, cmp_lt} = cmp;
        #1;
    endtask

    task automatic check(input string name, input outs_t e);
        outs_t a;
        a = sample();
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (mux|s|c|i|alu|ls|selc|reg|done|br|err|imm)",
                     name, a, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        n_vec++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    // Common expected-output shorthands (fields listed explicitly per row).
    outs_t e_wb_ld;
    int    n;

    initial begin
        // ---------------- vector table (one row per clock cycle) ----------------
        //           rst run ins      lsd cmp       mux  s  c  i  alu  ls    selc reg    dn br er imm
        add(0, 0, 16'h5400, 0, 3'b000, mk(4'd2, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h00A0)); // in reset
        // ALU: rx=2 ry=5
        add(1, 1, 16'h5400, 0, 3'b000, mk(4'd2, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h00A0)); // SRC
        add(1, 0, 16'h5400, 0, 3'b000, mk(4'd5, 0, 1, 0, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h00A0)); // EXEC
        add(1, 0, 16'h5400, 0, 3'b000, mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 0, 8'h04, 1, 0, 0, 16'h00A0)); // WB
        add(1, 0, 16'h5400, 0, 3'b000, mk(4'd2, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h00A0)); // SRC idle
        // Immediate: rx=1, imm8=0x2A
        add(1, 1, 16'h2541, 0, 3'b000, mk(4'd1, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h002A));
        add(1, 0, 16'h2541, 0, 3'b000, mk(4'd8, 0, 1, 0, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h002A));
        add(1, 0, 16'h2541, 0, 3'b000, mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 0, 8'h02, 1, 0, 0, 16'h002A));
        // Load: rx=3 ry=4, ls_done on third LSWAIT cycle
        add(1, 1, 16'h7003, 0, 3'b000, mk(4'd3, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 0, 16'h7003, 1, 3'b000, mk(4'd4, 0, 1, 0, 3'd0, 2'b01, 1, 8'h00, 0, 0, 0, 16'h0080)); // EXEC ignores ls_done
        add(1, 0, 16'h7003, 0, 3'b000, mk(4'd4, 0, 1, 0, 3'd0, 2'b01, 1, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 0, 16'h7003, 0, 3'b000, mk(4'd4, 0, 1, 0, 3'd0, 2'b01, 1, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 0, 16'h7003, 1, 3'b000, mk(4'd4, 0, 1, 0, 3'd0, 2'b01, 1, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 0, 16'h7003, 0, 3'b000, mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 1, 8'h08, 1, 0, 0, 16'h0080));
        // Store: alu_op=1, no register write; run held during WB is ignored
        add(1, 1, 16'h7007, 0, 3'b000, mk(4'd3, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 0, 16'h7007, 0, 3'b000, mk(4'd4, 0, 1, 0, 3'd1, 2'b10, 1, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 0, 16'h7007, 1, 3'b000, mk(4'd4, 0, 1, 0, 3'd1, 2'b10, 1, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 1, 16'h7007, 0, 3'b000, mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 1, 8'h00, 1, 0, 0, 16'h0080));
        // Branch always (cond 11), target 0x123
        add(1, 0, 16'h123E, 0, 3'b000, mk(4'd9, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0123));
        add(1, 1, 16'h123E, 0, 3'b000, mk(4'd9, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0123));
        add(1, 0, 16'h123E, 0, 3'b000, mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 1, 1, 0, 16'h0123));
        // Branch on eq, eq=0 (gt/lt set to show they are not selected)
        add(1, 1, 16'h1232, 0, 3'b011, mk(4'd9, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0123));
        add(1, 0, 16'h1232, 0, 3'b011, mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 1, 0, 0, 16'h0123));
        // Branch on eq, eq=1
        add(1, 1, 16'h1232, 0, 3'b100, mk(4'd9, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0123));
        add(1, 0, 16'h1232, 0, 3'b100, mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 1, 1, 0, 16'h0123));
        // Branch on gt, gt=1
        add(1, 1, 16'h1236, 0, 3'b010, mk(4'd9, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0123));
        add(1, 0, 16'h1236, 0, 3'b010, mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 1, 1, 0, 16'h0123));
        // Branch on lt, lt=0 (gt=1)
        add(1, 1, 16'h123A, 0, 3'b010, mk(4'd9, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0123));
        add(1, 0, 16'h123A, 0, 3'b010, mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 1, 0, 0, 16'h0123));
        // Branch on lt, lt=1
        add(1, 1, 16'h123A, 0, 3'b001, mk(4'd9, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0123));
        add(1, 0, 16'h123A, 0, 3'b001, mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 0, 8'h00, 1, 1, 0, 16'h0123));
        // Reset during LSWAIT: back to SRC immediately, no done / en_reg
        add(1, 1, 16'h7003, 0, 3'b000, mk(4'd3, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 0, 16'h7003, 0, 3'b000, mk(4'd4, 0, 1, 0, 3'd0, 2'b01, 1, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 0, 16'h7003, 0, 3'b000, mk(4'd4, 0, 1, 0, 3'd0, 2'b01, 1, 8'h00, 0, 0, 0, 16'h0080));
        add(0, 0, 16'h7003, 1, 3'b000, mk(4'd3, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 0, 16'h7003, 1, 3'b000, mk(4'd3, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0080));
        add(1, 0, 16'h7003, 1, 3'b000, mk(4'd3, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0080));

        #1;
        check("reset_t0", mk(4'd0, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0000));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_b, vecs[i].run, vecs[i].ins, vecs[i].lsd, vecs[i].cmp);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        e_wb_ld = mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 1, 8'h08, 1, 0, 0, 16'h0080);

`ifdef CU_LS_TIMEOUT_EN
        // ---------------- timeout: ls_done never arrives ----------------
        drive(1, 1, 16'h7003, 0, 3'b000);   // SRC
        drive(1, 0, 16'h7003, 0, 3'b000);   // EXEC
        n = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 16'h7003, 0, 3'b000);
            if (done === 1'b1) break;
            n++;
        end
        check_int("timeout_lswait_cycles", n, LS_TIMEOUT);
        check("timeout_wb", mk(4'd0, 0, 0, 1, 3'd0, 2'b00, 1, 8'h00, 1, 0, 1, 16'h0080));
        drive(1, 0, 16'h7003, 0, 3'b000);
        check("timeout_err_cleared", mk(4'd3, 1, 0, 1, 3'd0, 2'b00, 0, 8'h00, 0, 0, 0, 16'h0080));

        // ---------------- ls_done on the last permitted cycle ----------------
        drive(1, 1, 16'h7003, 0, 3'b000);
        drive(1, 0, 16'h7003, 0, 3'b000);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 16'h7003, (n == LS_TIMEOUT - 1), 3'b000);
            if (done === 1'b1) break;
            n++;
        end
        check_int("lastcycle_lswait_cycles", n, LS_TIMEOUT);
        check("lastcycle_wb", e_wb_ld);
`else
        // ---------------- no timeout built: wait well past LS_TIMEOUT ----------------
        drive(1, 1, 16'h7003, 0, 3'b000);
        drive(1, 0, 16'h7003, 0, 3'b000);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, 16'h7003, 0, 3'b000);
            if (done === 1'b1 || ls_err !== 1'b0) break;
            n++;
        end
        check_int("nowait_bound_lswait_cycles", n, 12);
        drive(1, 0, 16'h7003, 1, 3'b000);
        check("nowait_last_lswait", mk(4'd4, 0, 1, 0, 3'd0, 2'b01, 1, 8'h00, 0, 0, 0, 16'h0080));
        drive(1, 0, 16'h7003, 0, 3'b000);
        check("nowait_wb", e_wb_ld);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
